// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fixed up on the way out.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OP_A,
    input  logic [XLEN-1:0] OP_B,
    input  logic            FLUSH,
    input  logic            MEM_BUSYWAIT,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [2:0]        func_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              neg_q;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc, acc_nxt;

    logic              is_div, a_signed, b_signed, a_neg, b_neg, res_neg;
    logic              accept, div_zero, div_ovf, special, last_iter;
    logic [XLEN-1:0]   a_abs, b_abs, special_res, final_res;

    assign is_div   = FUNC3[2];
    assign a_signed = is_div ? ~FUNC3[0] : ~(FUNC3[1] & FUNC3[0]);
    assign b_signed = is_div ? ~FUNC3[0] : ~FUNC3[1];
    assign a_neg    = a_signed & OP_A[XLEN-1];
    assign b_neg    = b_signed & OP_B[XLEN-1];
    assign a_abs    = a_neg ? -OP_A : OP_A;
    assign b_abs    = b_neg ? -OP_B : OP_B;
    // Remainder takes the dividend's sign; everything else the XOR of both.
    assign res_neg  = (is_div & FUNC3[1]) ? a_neg : (a_neg ^ b_neg);

    assign accept   = (state == S_IDLE) & START & ~FLUSH;
    assign div_zero = is_div & (OP_B == '0);
    assign div_ovf  = is_div & ~FUNC3[0] & (OP_A == MIN_NEG) & (OP_B == '1);
    assign special  = div_zero | div_ovf;
    assign special_res = div_zero ? (FUNC3[1] ? OP_A : '1)
                                  : (FUNC3[1] ? '0 : MIN_NEG);
    assign last_iter = (count == CW'(XLEN-1));

    assign BUSY = accept | (state == S_CALC);
    assign DONE = (state == S_DONE);

    // One iteration: multiply keeps {partial product, remaining multiplier};
    // divide keeps {partial remainder, dividend bits shifting into quotient}.
    logic [XLEN:0]     mul_sum, rem_sh;
    logic [XLEN-1:0]   diff, quo_rem;
    logic [2*XLEN-1:0] prod;
    logic              ge;
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_q} : '0);
        rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge      = rem_sh >= {1'b0, b_q};
        diff    = rem_sh[XLEN-1:0] - b_q;
        if (func_q[2])
            acc_nxt = ge ? {diff, acc[XLEN-2:0], 1'b1}
                         : {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        prod    = neg_q ? -acc_nxt : acc_nxt;
        quo_rem = func_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
        if (func_q[2])
            final_res = neg_q ? -quo_rem : quo_rem;
        else if (func_q[1:0] == 2'b00)
            final_res = prod[XLEN-1:0];
        else
            final_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (FLUSH)          state_nxt = S_IDLE;
                else if (last_iter) state_nxt = S_DONE;
            end
            S_DONE: if (FLUSH || !MEM_BUSYWAIT) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            func_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            count  <= '0;
            acc    <= '0;
            RESULT <= '0;
        end else if (accept) begin
            func_q <= FUNC3;
            a_q    <= a_abs;
            b_q    <= b_abs;
            neg_q  <= res_neg;
            count  <= '0;
            acc    <= {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
            if (special) RESULT <= special_res;
        end else if (state == S_CALC && !FLUSH) begin
            acc   <= acc_nxt;
            count <= count + 1'b1;
            if (last_iter) RESULT <= final_res;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomised + directed bench for ex_muldiv_unit; a negedge monitor scores every DONE pulse
// against a queue of expected results filled by the driver.
module tb_ex_muldiv_unit;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [2:0]  FUNC3 = '0;
    logic [31:0] OP_A = '0, OP_B = '0;
    logic        FLUSH = 1'b0;
    logic        MEM_BUSYWAIT = 1'b0;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNC3(FUNC3), .OP_A(OP_A), .OP_B(OP_B),
        .FLUSH(FLUSH), .MEM_BUSYWAIT(MEM_BUSYWAIT), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] res; int start; int lat; } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0;
    logic prev_done = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model from the ISA definition using 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, ua, ub, p;
        sa = longint'($signed(a)); sb_ = longint'($signed(b));
        ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb_; return p[31:0];  end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = sa / sb_; return p[31:0]; end
            3'd5: begin if (b == 0) return '1; p = ua / ub;  return p[31:0]; end
            3'd6: begin if (b == 0) return a;  p = sa % sb_; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return MINV;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor: one pop per rising DONE.
    always @(negedge CLK) begin
        if (DONE && !prev_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", RESULT, e.res);
                chk("latency", 32'(cyc - e.start), 32'(e.lat));
            end
        end
        prev_done <= DONE;
    end

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        FUNC3 = f; OP_A = a; OP_B = b; START = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res);
        int n;
        bit busy_ok;
        start_op(f, a, b);
        sb.push_back('{exp_res, start_cyc, ref_lat(f, a, b)});
        busy_ok = 1; n = 0;
        #1;
        while (!DONE && n < 40) begin
            if (!BUSY) busy_ok = 0;
            @(negedge CLK);
            n++;
        end
        chk("done_timeout", 32'(n < 40), 32'd1);
        chk("busy_while_working", 32'(busy_ok), 32'd1);
        chk("busy_in_done", 32'(BUSY), 32'd0);
        START = 1'b0;
        @(negedge CLK);
        chk("done_single_pulse", 32'(DONE), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_res;
        #2;
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_result", RESULT, 32'd0);
        @(negedge CLK); RESET = 1'b0;

        // Directed cases with expected values written out.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op(3'd1, MINV, MINV, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op(3'd4, MINV, 32'hFFFF_FFFF, MINV);
        run_op(3'd6, MINV, 32'hFFFF_FFFF, 32'h0);
        run_op(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd100, 32'd0, 32'h0000_0064);
        last_res = 32'h0000_0064;

        // Flush in cycle 10 of a DIVU: no DONE, RESULT kept.
        start_op(3'd5, 32'd1000, 32'd7);
        repeat (10) @(negedge CLK);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0; START = 1'b0;
        #1;
        chk("flush_busy", 32'(BUSY), 32'd0);
        chk("flush_done", 32'(DONE), 32'd0);
        chk("flush_result", RESULT, last_res);
        repeat (40) @(negedge CLK);
        chk("flush_result_held", RESULT, last_res);
        run_op(3'd0, 32'd3, 32'd5, 32'd15);

        // MEM_BUSYWAIT stretches DONE through cycle 36; IDLE in cycle 37.
        start_op(3'd0, 32'd6, 32'd7);
        sb.push_back('{32'd42, start_cyc, 33});
        repeat (33) @(negedge CLK);
        MEM_BUSYWAIT = 1'b1; START = 1'b0;
        chk("stall_done_c33", 32'(DONE), 32'd1);
        repeat (2) begin
            @(negedge CLK);
            chk("stall_done_held", 32'(DONE), 32'd1);
            chk("stall_result_held", RESULT, 32'd42);
        end
        @(negedge CLK);
        chk("stall_done_c36", 32'(DONE), 32'd1);
        MEM_BUSYWAIT = 1'b0;
        @(negedge CLK);
        chk("stall_idle_c37", 32'(DONE), 32'd0);
        chk("stall_idle_busy", 32'(BUSY), 32'd0);

        // Reset in cycle 20 of a MUL.
        start_op(3'd0, 32'd9, 32'd9);
        repeat (20) @(negedge CLK);
        RESET = 1'b1; START = 1'b0;
        #1;
        chk("midreset_busy", 32'(BUSY), 32'd0);
        chk("midreset_done", 32'(DONE), 32'd0);
        chk("midreset_result", RESULT, 32'd0);
        @(negedge CLK); RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("midreset_no_done", 32'(DONE), 32'd0);

        // Randomised ops scored against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick_op();
            b = pick_op();
            run_op(f, a, b, ref_model(f, a, b));
        end

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
